// File: rtl/aes_word_loader.sv
// Word-serial loader/unloader around an iterative AES-128 core: gathers key and plaintext
// words, starts the core, watches for completion and streams the ciphertext back out.
`timescale 1ns / 1ps
module aes_word_loader #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               key_hold,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_key,
  output logic [BLOCK_W-1:0] core_plaintext,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_cyphertext,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_last,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   block_count
);

  localparam int unsigned NWORDS = BLOCK_W / WORD_W;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned WD_W   = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadKey,
    StLoadPt,
    StStart,
    StWait,
    StSend
  } state_e;

  state_e                         state_q;
  logic [IDX_W-1:0]               word_cnt_q;
  logic                           key_loaded_q;
  logic [WD_W-1:0]                wd_cnt_q;
  logic [NWORDS-1:0][WORD_W-1:0]  key_q;
  logic [NWORDS-1:0][WORD_W-1:0]  pt_q;
  logic [NWORDS-1:0][WORD_W-1:0]  buf_q;
  logic                           in_xfer;
  logic                           out_xfer;
  logic [IDX_W-1:0]               word_pos;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  // Word 0 is the most-significant word, i.e. the highest packed index.
  assign word_pos = LAST_IDX - word_cnt_q;

  assign core_key       = key_q;
  assign core_plaintext = pt_q;
  assign out_data       = buf_q[word_pos];
  assign out_last       = (state_q == StSend) && (word_cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      word_cnt_q   <= '0;
      key_loaded_q <= 1'b0;
      wd_cnt_q     <= '0;
      key_q        <= '0;
      pt_q         <= '0;
      buf_q        <= '0;
      in_ready     <= 1'b0;
      core_start   <= 1'b0;
      out_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      block_count  <= '0;
    end else begin
      core_start  <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          in_ready <= 1'b1;
          state_q  <= (key_hold && key_loaded_q) ? StLoadPt : StLoadKey;
        end
        StLoadKey: begin
          if (in_xfer) begin
            key_q[word_pos] <= in_data;
            if (word_cnt_q == LAST_IDX) begin
              word_cnt_q   <= '0;
              key_loaded_q <= 1'b1;
              state_q      <= StLoadPt;
            end else begin
              word_cnt_q <= word_cnt_q + IDX_W'(1);
            end
          end
        end
        StLoadPt: begin
          if (in_xfer) begin
            pt_q[word_pos] <= in_data;
            if (word_cnt_q == LAST_IDX) begin
              word_cnt_q <= '0;
              in_ready   <= 1'b0;
              core_start <= 1'b1;
              wd_cnt_q   <= '0;
              state_q    <= StStart;
            end else begin
              word_cnt_q <= word_cnt_q + IDX_W'(1);
            end
          end
        end
        StStart: begin
          // The watchdog already counts the start cycle, so the abort pulse lands
          // exactly TIMEOUT cycles after core_start.
          wd_cnt_q <= wd_cnt_q + WD_W'(1);
          state_q  <= StWait;
        end
        StWait: begin
          if (core_done) begin
            buf_q      <= core_cyphertext;
            word_cnt_q <= '0;
            out_valid  <= 1'b1;
            state_q    <= StSend;
          end else if (wd_cnt_q == WD_LIMIT) begin
            timeout_err  <= 1'b1;
            key_loaded_q <= 1'b0;
            state_q      <= StIdle;
          end else begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
        end
        StSend: begin
          if (out_xfer) begin
            if (word_cnt_q == LAST_IDX) begin
              word_cnt_q  <= '0;
              out_valid   <= 1'b0;
              block_count <= block_count + CNT_W'(1);
              state_q     <= StIdle;
            end else begin
              word_cnt_q <= word_cnt_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed bench for aes_word_loader using the FIPS-197 Appendix B vector and a
// fixed-latency core model.
`timescale 1ns / 1ps
module tb_aes_word_loader;

  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         key_hold;
  logic         core_start;
  logic [127:0] core_key;
  logic [127:0] core_plaintext;
  logic         core_done;
  logic [127:0] core_cyphertext;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         timeout_err;
  logic [15:0]  block_count;

  aes_word_loader #(
    .WORD_W (32),
    .BLOCK_W(128),
    .TIMEOUT(64),
    .CNT_W  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .key_hold       (key_hold),
    .core_start     (core_start),
    .core_key       (core_key),
    .core_plaintext (core_plaintext),
    .core_done      (core_done),
    .core_cyphertext(core_cyphertext),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .timeout_err    (timeout_err),
    .block_count    (block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] stim [8];
  logic [31:0] exp_ct [4];
  initial begin
    stim[0] = 32'h2b7e1516; stim[1] = 32'h28aed2a6; stim[2] = 32'habf71588; stim[3] = 32'h09cf4f3c;
    stim[4] = 32'h3243f6a8; stim[5] = 32'h885a308d; stim[6] = 32'h313198a2; stim[7] = 32'he0370734;
    exp_ct[0] = 32'h3925841d; exp_ct[1] = 32'h02dc09fb;
    exp_ct[2] = 32'hdc118597; exp_ct[3] = 32'h196a0b32;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle counter and passive monitors, all sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned start_cnt = 0, err_cnt = 0, ov_cnt = 0;
  int unsigned start_cyc = 0, err_cyc = 0, last_in_cyc = 0;
  logic [31:0] out_q [$];
  bit          last_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
      check_val("start_latency", 128'(cyc), 128'(last_in_cyc + 1));
    end
    if (in_valid && in_ready) last_in_cyc <= cyc;
    if (timeout_err) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (out_valid) ov_cnt <= ov_cnt + 1;
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      last_q.push_back(out_last);
    end
  end

  // Core model: done strobe 11 cycles after start, FIPS-197 ciphertext.
  bit          core_en = 1'b1;
  bit          pending = 1'b0;
  int unsigned done_at = 0;
  assign core_cyphertext = CT;
  initial core_done = 1'b0;

  always @(negedge clk) begin
    core_done <= core_en && pending && (cyc == done_at);
    if (reset) begin
      pending <= 1'b0;
    end else if (core_en && core_start) begin
      pending <= 1'b1;
      done_at <= cyc + 11;
    end else if (pending && cyc == done_at) begin
      pending <= 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int first, input int n, input bit gaps);
    bit acc;
    for (int k = 0; k < n; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) next_cycle();
      in_valid = 1'b1;
      in_data  = stim[first + k];
      acc      = 1'b0;
      for (int t = 0; t < 60 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        next_cycle();
      end
      in_valid = 1'b0;
      check_val("feed_accept", 128'(acc), 128'(1));
    end
  endtask

  task automatic drain(input int stall_word, input int stall_len, input bit next_hold);
    int base;
    int left;
    key_hold  = next_hold;
    base      = out_q.size();
    left      = stall_len;
    out_ready = 1'b1;
    for (int t = 0; t < 300 && out_q.size() < base + 4; t++) begin
      if (out_valid && out_q.size() == base + stall_word && left > 0) begin
        out_ready = 1'b0;
        left--;
        check_val("held_data", 128'(out_data), 128'(exp_ct[stall_word]));
      end else begin
        out_ready = 1'b1;
      end
      next_cycle();
    end
    out_ready = 1'b1;
    repeat (2) next_cycle();
    check_val("out_count", 128'(out_q.size() - base), 128'(4));
    for (int i = 0; i < 4; i++) begin
      if (base + i < out_q.size()) begin
        check_val("out_word", 128'(out_q[base + i]), 128'(exp_ct[i]));
        check_val("out_last", 128'(last_q[base + i]), 128'(i == 3));
      end
    end
  endtask

  task automatic check_outputs_zero();
    check_val("rst_in_ready", 128'(in_ready), 128'(0));
    check_val("rst_core_start", 128'(core_start), 128'(0));
    check_val("rst_core_key", core_key, 128'(0));
    check_val("rst_core_pt", core_plaintext, 128'(0));
    check_val("rst_out_valid", 128'(out_valid), 128'(0));
    check_val("rst_out_data", 128'(out_data), 128'(0));
    check_val("rst_out_last", 128'(out_last), 128'(0));
    check_val("rst_timeout_err", 128'(timeout_err), 128'(0));
    check_val("rst_block_count", 128'(block_count), 128'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int unsigned s0, e0, o0;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; key_hold = 1'b0; out_ready = 1'b1;
    repeat (3) next_cycle();
    check_outputs_zero();
    reset = 1'b0;

    // FIPS-197 block with a full key load.
    s0 = start_cnt;
    feed(0, 8, 1'b0);
    check_val("fips_start", 128'(core_start), 128'(1));
    check_val("fips_ready_low", 128'(in_ready), 128'(0));
    drain(-1, 0, 1'b1);
    check_val("fips_key", core_key, KEY);
    check_val("fips_pt", core_plaintext, PT);
    check_val("fips_count", 128'(block_count), 128'(1));
    check_val("fips_starts", 128'(start_cnt - s0), 128'(1));

    // Key reuse: only four plaintext words.
    feed(4, 4, 1'b0);
    check_val("reuse_ready_drop", 128'(in_ready), 128'(0));
    check_val("reuse_start", 128'(core_start), 128'(1));
    check_val("reuse_key", core_key, KEY);
    drain(-1, 0, 1'b0);
    check_val("reuse_count", 128'(block_count), 128'(2));

    // Input gaps and a 5-cycle output stall on the second word.
    feed(0, 8, 1'b1);
    drain(1, 5, 1'b0);
    check_val("bp_count", 128'(block_count), 128'(3));

    // Watchdog abort with a silent core.
    core_en = 1'b0;
    e0 = err_cnt;
    o0 = ov_cnt;
    feed(0, 8, 1'b0);
    key_hold = 1'b1;
    for (int t = 0; t < 200 && err_cnt == e0; t++) next_cycle();
    repeat (5) next_cycle();
    check_val("to_pulses", 128'(err_cnt - e0), 128'(1));
    check_val("to_delay", 128'(err_cyc - start_cyc), 128'(64));
    check_val("to_no_out", 128'(ov_cnt - o0), 128'(0));
    check_val("to_count", 128'(block_count), 128'(3));

    // After the abort the key must be reloaded despite key_hold.
    core_en = 1'b1;
    s0 = start_cnt;
    feed(0, 4, 1'b0);
    check_val("to_reload_no_start", 128'(core_start), 128'(0));
    check_val("to_reload_ready", 128'(in_ready), 128'(1));
    feed(4, 4, 1'b0);
    drain(-1, 0, 1'b0);
    check_val("to_reload_starts", 128'(start_cnt - s0), 128'(1));
    check_val("to_reload_count", 128'(block_count), 128'(4));

    // Reset after three plaintext words.
    s0 = start_cnt;
    feed(0, 7, 1'b0);
    reset = 1'b1;
    next_cycle();
    check_outputs_zero();
    key_hold = 1'b1;
    reset = 1'b0;
    repeat (3) next_cycle();
    check_val("rst_no_start", 128'(start_cnt - s0), 128'(0));
    feed(0, 8, 1'b0);
    check_val("rst_full_start", 128'(core_start), 128'(1));
    drain(-1, 0, 1'b0);
    check_val("rst_after_count", 128'(block_count), 128'(1));
    check_val("rst_after_starts", 128'(start_cnt - s0), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_word_loader.md
Name: aes_word_loader

Overview:
- Word-serial front/back end for the iterative AES-128 encryption core.
- Assembles a 128-bit key and a 128-bit plaintext from 32-bit streaming words, then pulses the core's start.
- Waits for the core's done strobe, then streams the 128-bit ciphertext back out as 32-bit words.
- Sits directly upstream of the core (feeds plaintext/key/start) and directly downstream of it (consumes the ciphertext).

Parameters:
- WORD_W, 32, stream word width; BLOCK_W/WORD_W must be an integer (4 at defaults).
- BLOCK_W, 128, AES block and key width.
- TIMEOUT, 64, maximum cycles in WAIT without core_done before abort; must be ≥2.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset. Interface is fixed as one clock; reset is synchronous and active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts input word.
- in_data  in  WORD_W  input word; most-significant word of each 128-bit value first.
- key_hold  in  1  sampled in IDLE; 1 = reuse the stored key and skip the key load.
- core_start  out  1  one-cycle start pulse to the core.
- core_key  out  BLOCK_W  registered key to the core.
- core_plaintext  out  BLOCK_W  registered plaintext to the core.
- core_done  in  1  one-cycle completion strobe from the core.
- core_cyphertext  in  BLOCK_W  core result; valid in the core_done cycle.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts output word.
- out_data  out  WORD_W  ciphertext word, most-significant first.
- out_last  out  1  marks the final word of a block.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- block_count  out  CNT_W  number of completed blocks; wraps.

Behaviour:
- Reset (sync, high): state=IDLE; word_cnt=0; key_loaded=0; core_key, core_plaintext and the output buffer =0; every output =0.
- Transfer rules:
  - Input transfer: in_valid & in_ready at a clk edge.
  - Output transfer: out_valid & out_ready at a clk edge.
- IDLE: in_ready=0. Next state is LOAD_PT if key_hold & key_loaded, else LOAD_KEY. IDLE always lasts exactly 1 cycle.
- LOAD_KEY:
  - in_ready=1. Each transfer writes word word_cnt (0 = bits 127:96) of core_key.
  - word_cnt increments; after the 4th transfer: word_cnt=0, key_loaded=1, go to LOAD_PT.
- LOAD_PT:
  - in_ready=1. Same write scheme into core_plaintext.
  - After the 4th transfer: go to START.
- START:
  - core_start=1 for exactly this one cycle, i.e. the cycle after the final plaintext word is accepted.
  - Watchdog counter cleared; go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - core_done=1: latch core_cyphertext into the output buffer, word_cnt=0, go to SEND. out_valid rises the next cycle.
  - Watchdog reaches TIMEOUT-1 without done: timeout_err=1 for one cycle, key_loaded=0, go to IDLE.
  - Done has priority if it coincides with the timeout cycle.
- SEND:
  - out_valid=1; out_data = buffer word word_cnt; out_last=1 when word_cnt=3.
  - out_data is stable while out_valid & !out_ready.
  - On the last transfer: block_count+1 (mod 2^CNT_W), go to IDLE.
- core_done outside WAIT is ignored.
- in_valid outside the LOAD states is ignored; no transfer occurs.
- core_key and core_plaintext hold their values after START until overwritten by a new load; the core may sample them at any time before done.
- Reset mid-operation (any state): immediate return to reset values, including key_loaded=0. A partial block is discarded and no output words are emitted.
- Throughput at full handshake: 1 (IDLE) + 8 (load) + 1 (START) + core latency + 1 + 4 (send) cycles. With key_hold, the 4 key cycles are removed.

Test Plan:
- FIPS-197 vector:
  - Stimulus: key words 2b7e1516, 28aed2a6, abf71588, 09cf4f3c, then pt 3243f6a8, 885a308d, 313198a2, e0370734; core model returns done after 11 cycles.
  - Required: core_start pulses once, the cycle after the 8th transfer; core_key=2b7e…4f3c; out words 3925841d, 02dc09fb, dc118597, 196a0b32; out_last on the 4th word; block_count=1.
- Key reuse:
  - Stimulus: second block with key_hold=1, 4 pt words only.
  - Required: in_ready drops after 4 words; core_key unchanged; block_count=2.
- key_hold=1 directly after reset:
  - Required: key_loaded=0, so the loader enters LOAD_KEY and consumes 8 words.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles during word 2; random gaps on in_valid.
  - Required: out_data is held at 02dc09fb; no word is lost or duplicated; same output words as the FIPS-197 case.
- Timeout:
  - Stimulus: core model never asserts done, TIMEOUT=64.
  - Required: timeout_err pulses exactly once, 64 cycles after core_start; out_valid is never asserted; the next block requires a full key load.
- Reset mid-load:
  - Stimulus: assert reset after 3 plaintext words.
  - Required: all outputs 0 on the next edge; no core_start; block_count=0; a subsequent full 8-word block completes normally.
